// File: rtl/cto3_pkg.sv
// Shared constants and reference function for the cto3 three-input Boolean block.
`timescale 1ns/1ps
package cto3_pkg;

   localparam logic [7:0] CTO3_TT = 8'b1010_1100;

   function automatic logic cto3_ref(input logic a, input logic b, input logic c);
      logic [2:0] idx;
      idx = {a, b, c};
      return CTO3_TT[idx];
   endfunction

endpackage

// File: rtl/cto3_core.sv
// Gate primitives and the gate-level sum-of-products netlist s_comb = (~a & b) | (a & c).
`timescale 1ns/1ps
module not_1 (
   input  logic x,
   output logic y
);
   assign y = ~x;
endmodule

module and_2 (
   input  logic x0,
   input  logic x1,
   output logic y
);
   assign y = x0 & x1;
endmodule

module or_2 (
   input  logic x0,
   input  logic x1,
   output logic y
);
   assign y = x0 | x1;
endmodule

module and_3 (
   input  logic x0,
   input  logic x1,
   input  logic x2,
   output logic y
);
   assign y = x0 & x1 & x2;
endmodule

module or_3 (
   input  logic x0,
   input  logic x1,
   input  logic x2,
   output logic y
);
   assign y = x0 | x1 | x2;
endmodule

module cto3_core (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s_comb
);
   logic na;
   logic p0;
   logic p1;

   not_1 u_na (.x(a), .y(na));
   and_2 u_p0 (.x0(na), .x1(b), .y(p0));
   // Spare inputs of the 3-input gates are tied to their identity values.
   and_3 u_p1 (.x0(a), .x1(1'b1), .x2(c), .y(p1));
   or_3  u_s  (.x0(p0), .x1(p1), .x2(1'b0), .y(s_comb));
endmodule

// File: rtl/cto3_clase.sv
// Three-input Boolean function with a live combinational result and an optional registered result stage.
`timescale 1ns/1ps
module cto3_clase
   import cto3_pkg::*;
#(
   parameter int OUT_REG = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic in_valid,
   output logic s,
   output logic s_comb,
   output logic out_valid
);

   logic s_comb_p0;

   cto3_core u_core (
      .a      (a),
      .b      (b),
      .c      (c),
      .s_comb (s_comb_p0)
   );

   assign s_comb = s_comb_p0;

   generate
      if (OUT_REG != 0) begin : g_reg
         logic s_p1;
         logic vld_p1;

         // p0 -> p1: capture the result only for qualified inputs, otherwise hold it
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s_p1   <= 1'b0;
               vld_p1 <= 1'b0;
            end else begin
               vld_p1 <= in_valid;
               if (in_valid) begin
                  s_p1 <= s_comb_p0;
               end
            end
         end

         assign s         = s_p1;
         assign out_valid = vld_p1;

         a_golden : assert property (@(posedge clk) disable iff (!rst_n)
            !$isunknown({a, b, c}) |-> (s_comb_p0 == cto3_ref(a, b, c)));
      end else begin : g_comb
         logic unused_clk_rst;
         assign unused_clk_rst = ^{clk, rst_n};
         assign s              = s_comb_p0;
         assign out_valid      = in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_cto3_clase.sv
// Bench for cto3_clase: registered and pass-through builds against a behavioural model.
`timescale 1ns/100ps
module tb_cto3_clase;

   logic clk;
   logic rst_n;
   logic a, b, c;
   logic in_valid;
   logic s1, s_comb1, vld1;
   logic s0, s_comb0, vld0;

   int n_cmp;
   int n_fail;
   bit check_en;

   logic m_s;
   logic m_v;

   cto3_clase #(.OUT_REG(1)) u_reg (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
      .s(s1), .s_comb(s_comb1), .out_valid(vld1)
   );

   cto3_clase #(.OUT_REG(0)) u_comb (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .in_valid(in_valid),
      .s(s0), .s_comb(s_comb0), .out_valid(vld0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference function: a selects between c (a=1) and b (a=0).
   function automatic logic ref_f(input logic [2:0] abc);
      return abc[2] ? abc[0] : abc[1];
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the registered build: last qualified result since reset, and previous in_valid.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s <= 1'b0;
         m_v <= 1'b0;
      end else begin
         m_v <= in_valid;
         if (in_valid) m_s <= ref_f({a, b, c});
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_s",       s1,      m_s);
         chk("cmp_vld",     vld1,    m_v);
         chk("cmp_scomb",   s_comb1, ref_f({a, b, c}));
         chk("cmp_s_or0",   s0,      ref_f({a, b, c}));
         chk("cmp_scomb0",  s_comb0, ref_f({a, b, c}));
         chk("cmp_vld_or0", vld0,    in_valid);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] abc, input logic v);
      {a, b, c} = abc;
      in_valid  = v;
   endtask

   initial begin
      logic [7:0] tt;
      logic [2:0] rabc;
      n_cmp    = 0;
      n_fail   = 0;
      check_en = 1'b0;
      tt       = 8'b1010_1100;

      // Reset held with a qualified input present
      rst_n = 1'b0;
      drive(3'b011, 1'b1);
      #1;
      check_en = 1'b1;
      repeat (3) begin
         step();
         chk("rst_s",   s1,   1'b0);
         chk("rst_vld", vld1, 1'b0);
      end
      rst_n = 1'b1;
      drive(3'b000, 1'b0);

      // Exhaustive combinational sweep at 1 ns steps, offset from both clock edges
      @(posedge clk);
      #0.5;
      for (int i = 0; i < 8; i++) begin
         rabc = 3'(i);
         drive(rabc, 1'b0);
         #1;
         chk("sweep_scomb",  s_comb1, tt[i]);
         chk("sweep_s_or0",  s0,      tt[i]);
      end

      // Latency and throughput
      step();
      drive(3'b010, 1'b1);
      step();
      chk("lat0_s", s1, 1'b1);
      chk("lat0_v", vld1, 1'b1);
      drive(3'b100, 1'b1);
      step();
      chk("lat1_s", s1, 1'b0);
      chk("lat1_v", vld1, 1'b1);
      drive(3'b111, 1'b1);
      step();
      chk("lat2_s", s1, 1'b1);
      chk("lat2_v", vld1, 1'b1);

      // Hold while unqualified
      drive(3'b101, 1'b1);
      step();
      chk("hold0_s", s1, 1'b1);
      drive(3'b000, 1'b0);
      repeat (3) begin
         step();
         chk("hold_s", s1, 1'b1);
         chk("hold_v", vld1, 1'b0);
      end

      // Mid-stream asynchronous reset
      drive(3'b011, 1'b1);
      step();
      chk("pre_rst_s", s1, 1'b1);
      chk("pre_rst_v", vld1, 1'b1);
      drive(3'b111, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_s", s1, 1'b0);
      chk("async_rst_v", vld1, 1'b0);
      rst_n = 1'b1;
      drive(3'b110, 1'b1);
      step();
      chk("post_rst_s", s1, 1'b0);
      chk("post_rst_v", vld1, 1'b1);

      // Randomized traffic with occasional mid-cycle reset pulses
      for (int n = 0; n < 400; n++) begin
         step();
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            #1;
            chk("rnd_rst_s", s1, 1'b0);
            chk("rnd_rst_v", vld1, 1'b0);
            rst_n = 1'b1;
         end
         drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      step();
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cto3_clase.md
Name: cto3_clase

Overview:
- Three-input Boolean function block built as a sum of products from gate primitives: NOT, 2-input AND, 2-input OR, 3-input AND, 3-input OR.
- Provides a raw combinational result `s_comb`.
- Provides a clocked, reset-controlled result `s` with a valid flag, so it can sit in a pipelined datapath.
- Leaf block; used as a class/reference circuit and as the golden function for gate-library checks.

Parameters:
- OUT_REG, default 1. 1 = `s`/`out_valid` registered (1-cycle latency); 0 = `s` driven by `s_comb`, `out_valid` = `in_valid`, no flops.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  1  function input, MSB of truth-table index
- b  input  1  function input, middle bit of index
- c  input  1  function input, LSB of index
- in_valid  input  1  qualifies a/b/c this cycle
- s  output  1  function result, registered per OUT_REG
- s_comb  output  1  combinational function result, always live
- out_valid  output  1  s holds a result for a qualified input

Behaviour:
- Function: s_comb = (~a & b) | (a & c).
  - Truth table for {a,b,c} = 000..111 is 0,0,1,1,0,1,0,1.
  - Equivalently TT = 8'b1010_1100, indexed by {a,b,c}.
- s_comb is purely combinational. It settles in the same delta as the inputs and does not depend on clk, rst_n or in_valid.
- Structural core realisation:
  - na = NOT(a).
  - p0 = AND(na, b).
  - p1 = AND3(a, 1'b1, c), using the 3-input gate with its spare input tied high.
  - s_comb = OR3(p0, p1, 1'b0).
- OUT_REG = 1:
  - rst_n low, asynchronously: s = 0, out_valid = 0, held while low.
  - Each rising clk edge with rst_n high: out_valid <= in_valid.
  - Same edge: if in_valid = 1, s <= s_comb; otherwise s holds its previous value.
  - Latency: exactly 1 clk from a qualified input to s/out_valid.
  - Back-to-back valid inputs produce one result per cycle; no stalls, no backpressure.
  - Reset deassertion is synchronised by the flop usage only; the first edge after rst_n rises may capture.
  - Reset mid-stream: any in-flight result is discarded and out_valid drops immediately.
- OUT_REG = 0:
  - s = s_comb and out_valid = in_valid, with no storage.
  - rst_n has no effect on either output.
- X on any input propagates to s_comb.
  - With OUT_REG = 1, X is captured into s only when in_valid = 1.

Decomposition:
- Package cto3_pkg:
  - localparam logic [7:0] CTO3_TT = 8'b1010_1100.
  - function cto3_ref(a,b,c), returning CTO3_TT[{a,b,c}], for benches and assertions.
- One sub-module, cto3_core:
  - Pure gate-level netlist instantiating the not/and/or/and_3/or_3 gate modules.
  - Output is s_comb.
- cto3_clase wraps cto3_core plus the OUT_REG output stage.
- Assertion, with OUT_REG = 1: s_comb == cto3_ref(a,b,c) whenever inputs are known.

Test Plan:
- Exhaustive combinational sweep: apply {a,b,c} = 000..111 at 1 ns steps -> s_comb = 0,0,1,1,0,1,0,1 respectively.
- Reset: hold rst_n = 0 with in_valid = 1 and abc = 011 -> s = 0, out_valid = 0 throughout; assert rst_n low mid-cycle -> outputs clear without waiting for clk.
- Latency/throughput (OUT_REG = 1): drive in_valid = 1 and abc = 010, 100, 111 on consecutive edges -> next edges give s = 1, 0, 1 with out_valid = 1 each cycle.
- Hold: valid abc = 101 (s becomes 1), then in_valid = 0 with abc = 000 for 3 cycles -> s stays 1, out_valid = 0.
- Mid-stream reset: pulse rst_n low between two valid inputs 011 and 111 -> s and out_valid = 0 immediately; next valid input 110 -> s = 0, out_valid = 1 one cycle later.
- OUT_REG = 0 build: sweep abc with in_valid toggling -> s tracks s_comb combinationally, out_valid == in_valid, clk and rst_n have no effect.
